// File: rtl/atomrvcore_pkg.sv
// ---------------------------------------------------------------------------
// atomrvcore_pkg
// Shared types and constants for the ICCM boot loader.
//   loader_state_e        : loader FSM states (HDR, DATA, CSUM, DONE, ERR)
//   LOADER_BYTES_PER_WORD : stream bytes that make one ICCM word
//   LOADER_WORD_BITS      : width of one assembled word
// ---------------------------------------------------------------------------
package atomrvcore_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam int LOADER_BYTES_PER_WORD = 4;
  localparam int LOADER_WORD_BITS      = 8 * LOADER_BYTES_PER_WORD;

endpackage

// File: rtl/atomrvcore_byte_packer.sv
// ---------------------------------------------------------------------------
// atomrvcore_byte_packer
// Collects accepted stream bytes little-endian into 32-bit words.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, drops any partial word
//   data_byte  in   stream byte
//   accept     in   data_byte is transferred this cycle
//   word_valid out  one-cycle pulse: this cycle's byte completes a word
//   word       out  completed word (meaningful while word_valid = 1)
// ---------------------------------------------------------------------------
module atomrvcore_byte_packer
  import atomrvcore_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_byte,
  input  logic                        accept,
  output logic                        word_valid,
  output logic [LOADER_WORD_BITS-1:0] word
);

  localparam int CNT_W = $clog2(LOADER_BYTES_PER_WORD);

  logic [LOADER_WORD_BITS-9:0] partial_q;
  logic [CNT_W-1:0]            cnt_q;

  // The word is completed combinationally from the three stored bytes and
  // the byte on the bus, so the loader can react in the same cycle the
  // last byte arrives.
  assign word       = {data_byte, partial_q};
  assign word_valid = accept && (cnt_q == CNT_W'(LOADER_BYTES_PER_WORD - 1));

  // Older bytes shift toward bit 0 so the first byte ends up lowest.
  // Stale bytes left after a completed word are overwritten before reuse.
  always_ff @(posedge clk) begin
    if (rst) begin
      partial_q <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      partial_q <= {data_byte, partial_q[LOADER_WORD_BITS-9:8]};
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atomrvcore_iccm_loader.sv
// ---------------------------------------------------------------------------
// atomrvcore_iccm_loader
// Boot loader: receives a byte stream (4-byte word count N, N data words,
// optional 4-byte checksum), writes the words into ICCM and then releases
// the core from reset.
// Optional feature macro: ATOMRVCORE_LOADER_CHECKSUM_EN enables the CSUM
// phase and the running word sum.
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   byte_i        in   boot stream byte
//   byte_valid_i  in   byte_i valid
//   byte_ready_o  out  loader accepts a byte this cycle
//   IWR_EN_o      out  ICCM write strobe
//   address_o     out  ICCM byte address
//   DATA_o        out  ICCM write data
//   PCrst_o       out  1 holds PC and register file in reset
//   done_o        out  image loaded, core released
//   err_o         out  load aborted
// ---------------------------------------------------------------------------
module atomrvcore_iccm_loader
  import atomrvcore_pkg::*;
#(
  parameter int                   DATAWIDTH  = 32,
  parameter int                   ICCM_WORDS = 1024,
  parameter logic [DATAWIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 IWR_EN_o,
  output logic [DATAWIDTH-1:0] address_o,
  output logic [DATAWIDTH-1:0] DATA_o,
  output logic                 PCrst_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CW = $clog2(ICCM_WORDS) + 1;

  loader_state_e               state_q, state_d;
  logic                        accept;
  logic                        word_valid;
  logic [LOADER_WORD_BITS-1:0] word;
  logic [CW-1:0]               word_cnt_q;
  logic [CW-1:0]               word_total_q;
  logic                        iwr_q;
  logic [DATAWIDTH-1:0]        addr_q;
  logic [DATAWIDTH-1:0]        data_q;
  logic                        done_q;

`ifdef ATOMRVCORE_LOADER_CHECKSUM_EN
  logic [31:0]                 sum_q;
`endif

  assign accept = byte_valid_i && byte_ready_o;

  atomrvcore_byte_packer u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .data_byte  (byte_i),
    .accept     (accept),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and flow control. DATA is left on the byte that completes
  // the last word; its write pulse is still issued by the datapath register
  // in the following cycle, so nothing is lost by leaving early.
  // Ready is masked while rst_i is high so no byte is taken across a reset.
  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      HDR: begin
        byte_ready_o = 1'b1;
        if (word_valid) begin
          if (word > LOADER_WORD_BITS'(ICCM_WORDS)) begin
            state_d = ERR;
          end else if (word == '0) begin
`ifdef ATOMRVCORE_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (word_valid && (word_cnt_q == word_total_q - CW'(1))) begin
`ifdef ATOMRVCORE_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
      CSUM: begin
        byte_ready_o = 1'b1;
`ifdef ATOMRVCORE_LOADER_CHECKSUM_EN
        if (word_valid) begin
          state_d = (word == sum_q) ? DONE : ERR;
        end
`endif
      end
      DONE: begin
      end
      ERR: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = ERR;
      end
    endcase
    if (rst_i) begin
      byte_ready_o = 1'b0;
    end
  end

  // Write datapath. Address and data only move when a data word completes,
  // so they hold between pulses. done is registered from the DONE state,
  // which places the core release one cycle after the final write pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt_q   <= '0;
      word_total_q <= '0;
      iwr_q        <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      iwr_q  <= 1'b0;
      done_q <= (state_q == DONE);
      if ((state_q == HDR) && word_valid) begin
        word_total_q <= word[CW-1:0];
      end
      if ((state_q == DATA) && word_valid) begin
        iwr_q      <= 1'b1;
        data_q     <= DATAWIDTH'(word);
        addr_q     <= BASE_ADDR + (DATAWIDTH'(word_cnt_q) << 2);
        word_cnt_q <= word_cnt_q + CW'(1);
      end
    end
  end

`ifdef ATOMRVCORE_LOADER_CHECKSUM_EN
  // Running 32-bit wrapping sum of the data words, ready well before the
  // four checksum bytes can have arrived.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if ((state_q == DATA) && word_valid) begin
      sum_q <= sum_q + word;
    end
  end
`endif

  assign IWR_EN_o  = iwr_q;
  assign address_o = addr_q;
  assign DATA_o    = data_q;
  assign done_o    = done_q;
  assign PCrst_o   = ~done_q;

endmodule

// File: doc/atomrvcore_iccm_loader.md
ATOMRVCORE_ICCM_LOADER -- requirements
Module: atomRVCORE_iccm_loader

Interface
REQ-001 Parameter DATAWIDTH, default 32, ICCM data and address width.
REQ-002 Parameter ICCM_WORDS, default 1024, maximum loadable word count.
REQ-003 Parameter BASE_ADDR, default 32'h0, byte address of the first written word.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 byte_i  input  8  boot stream byte.
REQ-008 byte_valid_i  input  1  byte_i valid.
REQ-009 byte_ready_o  output  1  loader accepts byte this cycle.
REQ-010 IWR_EN_o  output  1  ICCM write strobe.
REQ-011 address_o  output  DATAWIDTH  ICCM byte address.
REQ-012 DATA_o  output  DATAWIDTH  ICCM write data.
REQ-013 PCrst_o  output  1  core hold; 1 keeps PC and register file in reset.
REQ-014 done_o  output  1  image loaded, core released.
REQ-015 err_o  output  1  load aborted.

Function
REQ-016 A byte SHALL transfer only in a cycle where byte_valid_i and byte_ready_o are both 1; byte_valid_i alone has no effect.
REQ-017 Bytes SHALL pack little-endian: the first accepted byte of a group goes to bits [7:0], the fourth to [31:24].
REQ-018 States: HDR, DATA, CSUM, DONE, ERR; byte_ready_o SHALL be 1 in HDR, DATA, CSUM and 0 in DONE, ERR.
REQ-019 HDR: the first 4 bytes form word count N; if N > ICCM_WORDS go to ERR; if N == 0 go to CSUM (macro defined) or DONE (macro undefined); else go to DATA.
REQ-020 DATA: each completed word SHALL drive IWR_EN_o = 1 for exactly one cycle, the cycle after its 4th byte is accepted, with DATA_o = word and address_o = BASE_ADDR + 4*k (k = word index from 0).
REQ-021 address_o and DATA_o SHALL hold their last values while IWR_EN_o = 0.
REQ-022 Byte acceptance SHALL continue during the IWR_EN_o cycle; no bubble is required between words.
REQ-023 After word N-1 is accepted, the FSM SHALL leave DATA in the same cycle; the final IWR_EN_o pulse still occurs the following cycle.
REQ-024 DONE SHALL be entered only after the final write pulse; PCrst_o SHALL fall to 0 and done_o rise to 1 in the cycle after that pulse.
REQ-025 DONE and ERR are terminal; only rst_i leaves them.
REQ-026 ERR: err_o = 1, PCrst_o = 1, IWR_EN_o = 0.
REQ-027 The word counter SHALL be $clog2(ICCM_WORDS)+1 bits wide; address arithmetic wraps modulo 2^DATAWIDTH.

Reset
REQ-028 With rst_i = 1 at a clock edge, the state SHALL become HDR, byte and word counters 0, and the checksum accumulator 0.
REQ-029 The same edge SHALL set IWR_EN_o = 0, address_o = BASE_ADDR, DATA_o = 0, PCrst_o = 1, done_o = 0, err_o = 0, byte_ready_o = 0.
REQ-030 byte_ready_o SHALL be 1 from the first cycle after rst_i drops.
REQ-031 Reset mid-load SHALL discard any partial word and any pending write pulse.

Configuration
REQ-032 Macro ATOMRVCORE_LOADER_CHECKSUM_EN, when defined, SHALL enable CSUM: 4 bytes after the data form the expected sum; a 32-bit wrapping sum of all N data words equal to it goes to DONE, otherwise to ERR.
REQ-033 When the macro is undefined, CSUM SHALL be unreachable, no accumulator SHALL be built, and DATA (or HDR with N = 0) SHALL go directly to DONE.

Structure
REQ-034 Package atomRVCORE_pkg SHALL hold typedef enum loader_state_e {HDR, DATA, CSUM, DONE, ERR} and constant LOADER_BYTES_PER_WORD = 4.
REQ-035 Sub-module atomRVCORE_byte_packer SHALL perform the 4-byte shift/assemble and emit a one-cycle word_valid pulse.

Verification
REQ-036 Header 02 00 00 00, bytes 13 05 50 00 93 05 a0 00 -> IWR_EN_o pulses at address_o 0x0 with DATA_o 0x00500513, then 0x4 with 0x00a00593; then PCrst_o = 0, done_o = 1.
REQ-037 byte_valid_i toggled 1-0 every cycle through REQ-036 -> identical writes, and IWR_EN_o never asserted for a partial word.
REQ-038 Header for N = ICCM_WORDS+1 -> ERR, err_o = 1, PCrst_o stays 1, zero write pulses.
REQ-039 rst_i pulsed after 6 data bytes of REQ-036, then a full restream -> exactly 2 writes, starting at address 0x0.
REQ-040 Macro defined, REQ-036 stream + checksum 0x00f00aa6 -> DONE; checksum 0x00f00aa7 -> ERR after both writes.
REQ-041 Header 00 00 00 00 with macro undefined -> DONE two cycles later, no write pulses.
